// File: rtl/cv_link_pkg.sv
// Shared state encoding and default timing for the TMDS link bring-up sequencer.
package cv_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_SERDES_RST = 3'd2,
        ST_SETTLE     = 3'd3,
        ST_WAIT_FRAME = 3'd4,
        ST_ACTIVE     = 3'd5,
        ST_FAULT      = 3'd6,
        ST_ILLEGAL    = 3'd7
    } link_state_e;

    localparam int DEF_LOCK_STABLE_CYC  = 1024;
    localparam int DEF_SERDES_RST_CYC   = 16;
    localparam int DEF_SETTLE_CYC       = 64;
    localparam int DEF_HPD_DEBOUNCE_CYC = 65536;

    function automatic int cnt_width(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/cv_debounce.sv
// Hot-plug detect synchronizer and stability filter; the filtered level only
// moves after the synchronized input has disagreed with it for a full window.
module cv_debounce
    import cv_link_pkg::*;
#(
    parameter int HPD_DEBOUNCE_CYC = DEF_HPD_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic reset,
    input  logic hpd,
    output logic hpd_db
);

    localparam int CW = cnt_width(HPD_DEBOUNCE_CYC);
    localparam logic [CW-1:0] DB_LAST = CW'(HPD_DEBOUNCE_CYC - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          db_q;
    logic          db_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        // Agreement (including a bounce back) restarts the window.
        if (sync2_q != db_q) begin
            if (cnt_q == DB_LAST) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= hpd;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hpd_db = db_q;

endmodule

// File: rtl/cv_link_seq.sv
// Link bring-up sequencer: waits for hot-plug and stable PLL lock, pulses the
// serializer reset, blanks while settling, then enables video at a frame origin.
module cv_link_seq
    import cv_link_pkg::*;
#(
    parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
    parameter int SERDES_RST_CYC   = DEF_SERDES_RST_CYC,
    parameter int SETTLE_CYC       = DEF_SETTLE_CYC,
    parameter int HPD_DEBOUNCE_CYC = DEF_HPD_DEBOUNCE_CYC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       hpd,
    input  logic       frame_start,
    output logic       oserdes_reset,
    output logic       video_en,
    output logic       blank,
    output logic       link_up,
    output logic [2:0] state,
    output logic [7:0] retry_cnt
);

    localparam int CNT_W = cnt_width(max4(LOCK_STABLE_CYC, SERDES_RST_CYC,
                                          SETTLE_CYC, HPD_DEBOUNCE_CYC));
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(SERDES_RST_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    logic             hpd_db;
    link_state_e      state_q, state_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [7:0]       retry_q, retry_d;
    logic             oserdes_reset_q, oserdes_reset_d;
    logic             video_en_q, video_en_d;
    logic             blank_q, blank_d;
    logic             link_up_q, link_up_d;

    cv_debounce #(
        .HPD_DEBOUNCE_CYC(HPD_DEBOUNCE_CYC)
    ) u_hpd_debounce (
        .clk   (clk),
        .reset (reset),
        .hpd   (hpd),
        .hpd_db(hpd_db)
    );

    always_comb begin
        state_d = state_q;
        // Cable removal wins over lock loss so an unplug never counts as a retry.
        if (state_q != ST_IDLE && !hpd_db) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:       if (hpd_db) state_d = ST_WAIT_LOCK;
                ST_WAIT_LOCK:  if (pll_locked && lock_cnt_q == LOCK_LAST) state_d = ST_SERDES_RST;
                ST_SERDES_RST: if (!pll_locked) state_d = ST_FAULT;
                               else if (cyc_cnt_q == RST_LAST) state_d = ST_SETTLE;
                ST_SETTLE:     if (!pll_locked) state_d = ST_FAULT;
                               else if (cyc_cnt_q == SETTLE_LAST) state_d = ST_WAIT_FRAME;
                ST_WAIT_FRAME: if (!pll_locked) state_d = ST_FAULT;
                               else if (frame_start) state_d = ST_ACTIVE;
                ST_ACTIVE:     if (!pll_locked) state_d = ST_FAULT;
                ST_FAULT:      state_d = ST_WAIT_LOCK;
                default:       state_d = ST_IDLE;
            endcase
        end

        lock_cnt_d = '0;
        if (state_q == ST_WAIT_LOCK && state_d == ST_WAIT_LOCK && pll_locked) begin
            lock_cnt_d = lock_cnt_q + 1'b1;
        end

        cyc_cnt_d = cyc_cnt_q;
        if (state_d != state_q) begin
            cyc_cnt_d = '0;
        end else if (cyc_cnt_q != '1) begin
            cyc_cnt_d = cyc_cnt_q + 1'b1;
        end

        retry_d = retry_q;
        if (state_d == ST_FAULT && state_q != ST_FAULT && retry_q != 8'hFF) begin
            retry_d = retry_q + 1'b1;
        end

        // Outputs decoded from the next state so they line up with the state register.
        oserdes_reset_d = (state_d == ST_IDLE) || (state_d == ST_WAIT_LOCK) ||
                          (state_d == ST_SERDES_RST) || (state_d == ST_FAULT);
        video_en_d      = (state_d == ST_ACTIVE);
        blank_d         = (state_d != ST_ACTIVE);
        link_up_d       = (state_d == ST_ACTIVE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            lock_cnt_q      <= '0;
            cyc_cnt_q       <= '0;
            retry_q         <= 8'd0;
            oserdes_reset_q <= 1'b1;
            video_en_q      <= 1'b0;
            blank_q         <= 1'b1;
            link_up_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            lock_cnt_q      <= lock_cnt_d;
            cyc_cnt_q       <= cyc_cnt_d;
            retry_q         <= retry_d;
            oserdes_reset_q <= oserdes_reset_d;
            video_en_q      <= video_en_d;
            blank_q         <= blank_d;
            link_up_q       <= link_up_d;
        end
    end

    assign oserdes_reset = oserdes_reset_q;
    assign video_en      = video_en_q;
    assign blank         = blank_q;
    assign link_up       = link_up_q;
    assign state         = state_q;
    assign retry_cnt     = retry_q;

endmodule

// File: tb/tb_cv_link_seq.sv
// Directed bench for cv_link_seq: expected output vectors are queued as stimulus
// is applied and compared against the DUT one cycle later.
module tb_cv_link_seq;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK  = 3'd1;
    localparam logic [2:0] S_SERDES_RST = 3'd2;
    localparam logic [2:0] S_SETTLE     = 3'd3;
    localparam logic [2:0] S_WAIT_FRAME = 3'd4;
    localparam logic [2:0] S_ACTIVE     = 3'd5;
    localparam logic [2:0] S_FAULT      = 3'd6;

    logic       clk = 1'b0;
    logic       reset;
    logic       pll_locked;
    logic       hpd;
    logic       frame_start;
    logic       oserdes_reset;
    logic       video_en;
    logic       blank;
    logic       link_up;
    logic [2:0] state;
    logic [7:0] retry_cnt;

    always #5 clk = ~clk;

    cv_link_seq #(
        .LOCK_STABLE_CYC (8),
        .SERDES_RST_CYC  (4),
        .SETTLE_CYC      (4),
        .HPD_DEBOUNCE_CYC(4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pll_locked   (pll_locked),
        .hpd          (hpd),
        .frame_start  (frame_start),
        .oserdes_reset(oserdes_reset),
        .video_en     (video_en),
        .blank        (blank),
        .link_up      (link_up),
        .state        (state),
        .retry_cnt    (retry_cnt)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       osr;
        logic       ven;
        logic       blk;
        logic       lnk;
        logic [7:0] rc;
    } obs_t;

    obs_t       exp_q[$];
    string      tag_q[$];
    int         pass_cnt  = 0;
    int         check_cnt = 0;
    logic [7:0] exp_rc;

    function automatic obs_t exp_of(input logic [2:0] st, input logic [7:0] rc);
        obs_t e;
        e.st  = st;
        e.rc  = rc;
        e.osr = (st == S_IDLE) || (st == S_WAIT_LOCK) || (st == S_SERDES_RST) || (st == S_FAULT);
        e.ven = (st == S_ACTIVE);
        e.blk = (st != S_ACTIVE);
        e.lnk = (st == S_ACTIVE);
        return e;
    endfunction

    function automatic obs_t observed();
        obs_t o;
        o.st  = state;
        o.osr = oserdes_reset;
        o.ven = video_en;
        o.blk = blank;
        o.lnk = link_up;
        o.rc  = retry_cnt;
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [2:0] st);
        exp_q.push_back(exp_of(st, exp_rc));
        tag_q.push_back(tag);
    endtask

    task automatic drain();
        while (exp_q.size() > 0) begin
            obs_t  e;
            obs_t  o;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            o = observed();
            check_cnt++;
            assert (o === e) pass_cnt++;
            else $error("FAIL %s: observed st=%0d osr=%b ven=%b blk=%b lnk=%b rc=%0d, expected st=%0d osr=%b ven=%b blk=%b lnk=%b rc=%0d",
                        t, o.st, o.osr, o.ven, o.blk, o.lnk, o.rc, e.st, e.osr, e.ven, e.blk, e.lnk, e.rc);
        end
    endtask

    task automatic step(input string tag, input logic [2:0] st);
        push(tag, st);
        tick();
        drain();
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        check_cnt++;
        assert (obs == expv) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    // Bounded wait for a state; the number of cycles taken is itself checked.
    task automatic wait_state(input string tag, input logic [2:0] target, input int exp_cycles);
        int n;
        n = 0;
        while (state !== target && n < 200) begin
            tick();
            n++;
        end
        check_int({tag, "_cycles"}, n, exp_cycles);
        push(tag, target);
        drain();
    endtask

    // From a fresh WAIT_LOCK entry with pll_locked held high, walk to ACTIVE.
    task automatic bring_up();
        wait_state("lock_to_serdes_rst", S_SERDES_RST, 8);
        for (int i = 0; i < 3; i++) step("serdes_rst_hold", S_SERDES_RST);
        step("serdes_rst_to_settle", S_SETTLE);
        for (int i = 0; i < 3; i++) step("settle_hold", S_SETTLE);
        step("settle_to_wait_frame", S_WAIT_FRAME);
        step("wait_frame_hold", S_WAIT_FRAME);
        frame_start = 1'b1;
        step("frame_start_to_active", S_ACTIVE);
        frame_start = 1'b0;
        step("active_hold", S_ACTIVE);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        hpd         = 1'b0;
        pll_locked  = 1'b0;
        frame_start = 1'b0;
        exp_rc      = 8'd0;
        tick();
        tick();
        push("reset_state", S_IDLE);
        drain();
        reset = 1'b0;
        step("idle_without_hpd", S_IDLE);

        // Normal bring-up
        hpd        = 1'b1;
        pll_locked = 1'b1;
        wait_state("hpd_debounced_rise", S_WAIT_LOCK, 7);
        bring_up();

        // A 3-cycle hpd dropout is filtered
        hpd = 1'b0;
        for (int i = 0; i < 3; i++) step("hpd_short_low", S_ACTIVE);
        hpd = 1'b1;
        for (int i = 0; i < 8; i++) step("hpd_short_recover", S_ACTIVE);

        // Lock loss in ACTIVE
        pll_locked = 1'b0;
        exp_rc     = 8'd1;
        step("active_lock_loss_fault", S_FAULT);
        pll_locked = 1'b1;
        step("fault_to_wait_lock", S_WAIT_LOCK);

        // Lock glitch after 5 locked cycles restarts the lock count
        for (int i = 0; i < 5; i++) step("lock_count_partial", S_WAIT_LOCK);
        pll_locked = 1'b0;
        step("lock_glitch", S_WAIT_LOCK);
        pll_locked = 1'b1;
        for (int i = 0; i < 7; i++) step("relock_count", S_WAIT_LOCK);
        step("relock_to_serdes_rst", S_SERDES_RST);

        // Reset while settling
        for (int i = 0; i < 3; i++) step("serdes_rst_hold2", S_SERDES_RST);
        step("to_settle2", S_SETTLE);
        step("settle_hold2", S_SETTLE);
        reset  = 1'b1;
        exp_rc = 8'd0;
        step("reset_in_settle", S_IDLE);
        reset = 1'b0;
        wait_state("hpd_rise_after_reset", S_WAIT_LOCK, 7);
        bring_up();

        // One fault so retry_cnt is nonzero, then a long hpd drop
        pll_locked = 1'b0;
        exp_rc     = 8'd1;
        step("fault_before_unplug", S_FAULT);
        pll_locked = 1'b1;
        step("fault_to_wait_lock2", S_WAIT_LOCK);
        bring_up();
        hpd = 1'b0;
        for (int i = 0; i < 6; i++) step("hpd_long_low_filter", S_ACTIVE);
        step("hpd_unplug_to_idle", S_IDLE);
        hpd = 1'b1;
        wait_state("hpd_replug", S_WAIT_LOCK, 7);
        bring_up();

        // hpd_db fall coincident with lock loss: unplug wins, no retry
        hpd = 1'b0;
        for (int i = 0; i < 6; i++) step("hpd_low_prefall", S_ACTIVE);
        pll_locked = 1'b0;
        step("unplug_and_lock_loss", S_IDLE);
        pll_locked = 1'b1;
        hpd        = 1'b1;
        wait_state("hpd_replug2", S_WAIT_LOCK, 7);

        // 300 forced faults saturate retry_cnt
        for (int k = 0; k < 300; k++) begin
            wait_state("retry_lock", S_SERDES_RST, 8);
            pll_locked = 1'b0;
            if (exp_rc != 8'hFF) exp_rc = exp_rc + 8'd1;
            step("retry_fault", S_FAULT);
            pll_locked = 1'b1;
            step("retry_relock", S_WAIT_LOCK);
        end
        check_int("retry_saturated", int'(retry_cnt), 255);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/cv_link_seq.md
CV_LINK_SEQ -- requirements
Module: cv_link_seq

Interface
REQ-001 Parameter LOCK_STABLE_CYC, default 1024: consecutive cycles of pll_locked=1 required before serializer reset.
REQ-002 Parameter SERDES_RST_CYC, default 16: cycles oserdes_reset is held in SERDES_RST.
REQ-003 Parameter SETTLE_CYC, default 64: blanking cycles after oserdes_reset release.
REQ-004 Parameter HPD_DEBOUNCE_CYC, default 65536: cycles of stable synchronized hpd required to change hpd_db.
REQ-005 clk  input  1  pixel clock; all logic on rising edge; one clock only.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 pll_locked  input  1  clock generator lock, already in clk domain.
REQ-008 hpd  input  1  asynchronous hot-plug detect from connector.
REQ-009 frame_start  input  1  one-cycle pulse from the colorbar timing generator at frame origin.
REQ-010 oserdes_reset  output  1  reset to all four 10:1 serializers.
REQ-011 video_en  output  1  enables pixel data into TMDS encoders.
REQ-012 blank  output  1  forces control-period data on all channels.
REQ-013 link_up  output  1  link active indicator (LED drive).
REQ-014 state  output  3  current state code.
REQ-015 retry_cnt  output  8  count of FAULT entries since reset.

Function
REQ-016 State codes SHALL be IDLE=0, WAIT_LOCK=1, SERDES_RST=2, SETTLE=3, WAIT_FRAME=4, ACTIVE=5, FAULT=6; code 7 SHALL go to IDLE next cycle.
REQ-017 hpd SHALL pass a 2-flop synchronizer; hpd_db SHALL take the synchronized value only after it differs from hpd_db for HPD_DEBOUNCE_CYC consecutive cycles; any bounce restarts the count.
REQ-018 IDLE -> WAIT_LOCK when hpd_db=1.
REQ-019 WAIT_LOCK: lock counter increments each cycle pll_locked=1, clears when 0; -> SERDES_RST the cycle the counter reaches LOCK_STABLE_CYC.
REQ-020 SERDES_RST: -> SETTLE after exactly SERDES_RST_CYC cycles in state.
REQ-021 SETTLE: -> WAIT_FRAME after exactly SETTLE_CYC cycles in state.
REQ-022 WAIT_FRAME -> ACTIVE on the cycle after frame_start=1; first enabled pixel aligns to frame origin.
REQ-023 pll_locked=0 in SERDES_RST, SETTLE, WAIT_FRAME or ACTIVE -> FAULT next cycle.
REQ-024 FAULT: retry_cnt increments on entry, saturating at 255; -> WAIT_LOCK next cycle.
REQ-025 hpd_db=0 in any non-IDLE state -> IDLE next cycle; takes priority over lock loss (no retry_cnt increment).
REQ-026 Outputs registered, valid in the same cycle the state register holds the new state: oserdes_reset=1 in IDLE, WAIT_LOCK, SERDES_RST, FAULT, else 0; video_en=1 and blank=0 only in ACTIVE; link_up=1 only in ACTIVE.
REQ-027 In-state cycle counter SHALL clear on every state change; width sized by $clog2 of largest parameter plus 1.

Reset
REQ-028 On reset=1: state=IDLE, oserdes_reset=1, video_en=0, blank=1, link_up=0, retry_cnt=0, hpd_db=0, all counters and synchronizer flops 0.
REQ-029 reset asserted mid-operation SHALL override all transitions the same edge.

Structure
REQ-030 State codes and default timing constants SHALL live in package cv_link_pkg.
REQ-031 Debouncer SHALL be sub-module cv_debounce (synchronizer + stability counter, parameter HPD_DEBOUNCE_CYC).

Verification (LOCK_STABLE_CYC=8, SERDES_RST_CYC=4, SETTLE_CYC=4, HPD_DEBOUNCE_CYC=4)
REQ-032 hpd=1, pll_locked=1 steady, frame_start every 100 cycles -> states 1,2,3,4,5 in order; oserdes_reset low exactly 4 cycles before WAIT_FRAME; video_en rises the cycle after frame_start.
REQ-033 pll_locked glitches low 1 cycle after 5 locked cycles in WAIT_LOCK -> counter restarts; SERDES_RST entered only after 8 further locked cycles.
REQ-034 pll_locked=0 in ACTIVE -> FAULT next cycle, retry_cnt=1, video_en=0, oserdes_reset=1, then WAIT_LOCK; 300 forced faults -> retry_cnt=255.
REQ-035 hpd 3-cycle low pulse in ACTIVE -> no state change; 4+ cycles low -> IDLE, retry_cnt unchanged; simultaneous hpd_db fall and lock loss -> IDLE.
REQ-036 reset asserted in SETTLE -> next cycle all outputs at REQ-028 values.
